// File: rtl/axi_ready_policy_ctrl_if.sv
// Channel handshake bundle for axi_ready_policy_ctrl: VALID from the
// transmitting side, READY generated by the policy controller.
interface axi_ready_policy_ctrl_if;
  logic valid;
  logic ready;

  // The side that drives VALID and observes READY.
  modport master (output valid, input ready);
  // The READY generator: observes VALID and drives READY.
  modport slave  (input valid, output ready);
endinterface

// File: rtl/axi_ready_policy_ctrl.sv
// axi_ready_policy_ctrl: READY generator for one AXI channel with a run-time
// selectable back-pressure policy (NOBP, FIXED, RANDOM, SWITCH) and a
// saturating handshake counter.
// Optional build macro AXI_READY_STATS_EN enables the stall counter; without
// it stall_cnt is tied to zero.
module axi_ready_policy_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [3:0]  LOW_MASK = 4'hF,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_load,
  input  logic [1:0]             cfg_policy,
  input  logic [7:0]             cfg_low_cycles,
  input  logic [7:0]             cfg_high_beats,
  input  logic [CNT_W-1:0]       cfg_switch_beats,
  axi_ready_policy_ctrl_if.slave chan,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [1:0]             policy_active,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef enum logic [1:0] {POL_NOBP, POL_FIXED, POL_RANDOM, POL_SWITCH} policy_e;
  typedef enum logic {S_LOW, S_HIGH} state_e;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  policy_e          pol_q, pol_d;
  policy_e          pol_load;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       low_q, low_d;
  logic [7:0]       high_q, high_d;
  logic [CNT_W-1:0] switch_q, switch_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       rand_low_q, rand_low_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             ready_q, ready_d;
  logic [1:0]       pact_q, pact_d;

  logic             hs;
  logic [3:0]       lfsr_low;
  logic [CNT_W-1:0] beat_inc;
  logic             sw_rand;
  logic             rand_mode;
  logic [7:0]       cur_low;
  logic [7:0]       load_low;

  assign hs        = chan.valid & ready_q;
  assign lfsr_low  = lfsr_q[3:0] & LOW_MASK;
  assign beat_inc  = (hs && (beat_q != '1)) ? beat_q + CNT_ONE : beat_q;
  // SWITCH turns random as soon as the count (including this beat) reaches
  // the threshold, so READY can drop right after the threshold handshake.
  assign sw_rand   = (beat_inc >= switch_q);
  assign rand_mode = (pol_q == POL_RANDOM) || ((pol_q == POL_SWITCH) && sw_rand);
  assign cur_low   = rand_mode ? {4'b0000, rand_low_q} : low_q;
  // Galois LFSR, x^16+x^14+x^13+x^11, shifting right.
  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
  assign pol_load  = policy_e'(cfg_policy);

  // Next-state logic for the READY FSM, counters and latched configuration.
  always_comb begin
    state_d    = state_q;
    pol_d      = pol_q;
    cnt_d      = cnt_q;
    low_d      = low_q;
    high_d     = high_q;
    switch_d   = switch_q;
    rand_low_d = rand_low_q;
    beat_d     = beat_inc;
    pact_d     = pact_q;
    load_low   = 8'd0;

    if (cfg_load) begin
      // Reconfiguration wins over anything in flight, including this beat.
      pol_d      = pol_load;
      low_d      = cfg_low_cycles;
      high_d     = (cfg_high_beats == 8'd0) ? 8'd1 : cfg_high_beats;
      switch_d   = cfg_switch_beats;
      rand_low_d = lfsr_low;
      cnt_d      = 8'd0;
      beat_d     = '0;
      case (pol_load)
        POL_NOBP:   load_low = 8'd0;
        POL_FIXED:  load_low = cfg_low_cycles;
        POL_RANDOM: load_low = {4'b0000, lfsr_low};
        POL_SWITCH: load_low = (cfg_switch_beats == '0) ? {4'b0000, lfsr_low} : 8'd0;
        default:    load_low = 8'd0;
      endcase
      state_d = (load_low != 8'd0) ? S_LOW : S_HIGH;
      if (pol_load == POL_SWITCH)
        pact_d = (cfg_switch_beats == '0) ? 2'd2 : 2'd0;
      else
        pact_d = cfg_policy;
    end else begin
      if (pol_q == POL_SWITCH)
        pact_d = sw_rand ? 2'd2 : 2'd0;
      else
        pact_d = pol_q;

      case (state_q)
        S_LOW: begin
          if (!rand_mode && (pol_q != POL_FIXED)) begin
            // NOBP behaviour (also the first cycle after reset).
            state_d = S_HIGH;
            cnt_d   = 8'd0;
          end else if (cur_low == 8'd0) begin
            state_d = S_HIGH;
            cnt_d   = 8'd0;
          end else if (chan.valid) begin
            // Low time is measured in cycles the master is actually waiting.
            if (cnt_q == cur_low - 8'd1) begin
              state_d = S_HIGH;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_HIGH: begin
          if (hs) begin
            if (pol_q == POL_FIXED) begin
              if (cnt_q == high_q - 8'd1) begin
                cnt_d   = 8'd0;
                state_d = (low_q != 8'd0) ? S_LOW : S_HIGH;
              end else begin
                cnt_d = cnt_q + 8'd1;
              end
            end else if (rand_mode) begin
              // One beat per high phase, then a fresh random gap.
              rand_low_d = lfsr_low;
              cnt_d      = 8'd0;
              state_d    = (lfsr_low != 4'd0) ? S_LOW : S_HIGH;
            end
          end
        end
        default: state_d = S_LOW;
      endcase
    end

    ready_d = (state_d == S_HIGH);
  end

  // State and configuration registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_LOW;
      pol_q      <= POL_NOBP;
      cnt_q      <= 8'd0;
      low_q      <= 8'd0;
      high_q     <= 8'd1;
      switch_q   <= '0;
      lfsr_q     <= SEED_EFF;
      rand_low_q <= 4'd0;
      beat_q     <= '0;
      ready_q    <= 1'b0;
      pact_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      pol_q      <= pol_d;
      cnt_q      <= cnt_d;
      low_q      <= low_d;
      high_q     <= high_d;
      switch_q   <= switch_d;
      lfsr_q     <= lfsr_d;
      rand_low_q <= rand_low_d;
      beat_q     <= beat_d;
      ready_q    <= ready_d;
      pact_q     <= pact_d;
    end
  end

  assign chan.ready    = ready_q;
  assign beat_cnt      = beat_q;
  assign policy_active = pact_q;

`ifdef AXI_READY_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (cfg_load)
      stall_d = '0;
    else if (chan.valid && !ready_q && (stall_q != '1))
      stall_d = stall_q + CNT_ONE;
  end

  // Saturating count of cycles where the master waits on READY.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      stall_q <= '0;
    else
      stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_ready_policy_ctrl.sv
// Self-checking bench for axi_ready_policy_ctrl: directed scenarios followed
// by randomized traffic, all compared each cycle against a phase-based
// behavioural model (low-phase countdown / high-phase beat budget).
module tb_axi_ready_policy_ctrl;
  localparam int          CNT_W = 8;
  localparam int          MAXC  = (1 << CNT_W) - 1;
  localparam logic [3:0]  MASK  = 4'hF;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             cfg_load = 1'b0;
  logic [1:0]       cfg_policy = 2'd0;
  logic [7:0]       cfg_low_cycles = 8'd0;
  logic [7:0]       cfg_high_beats = 8'd0;
  logic [CNT_W-1:0] cfg_switch_beats = '0;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       policy_active;
  logic [CNT_W-1:0] stall_cnt;

  axi_ready_policy_ctrl_if chan_if ();

  axi_ready_policy_ctrl #(.CNT_W(CNT_W), .LOW_MASK(MASK), .SEED(SEED)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cfg_load         (cfg_load),
    .cfg_policy       (cfg_policy),
    .cfg_low_cycles   (cfg_low_cycles),
    .cfg_high_beats   (cfg_high_beats),
    .cfg_switch_beats (cfg_switch_beats),
    .chan             (chan_if),
    .beat_cnt         (beat_cnt),
    .policy_active    (policy_active),
    .stall_cnt        (stall_cnt)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ready;
  int          m_beats, m_stall, m_pol, m_low, m_high, m_sw, m_pact;
  int          m_low_left, m_high_left;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic model_reset();
    m_ready = 0; m_beats = 0; m_stall = 0; m_pol = 0; m_low = 0; m_high = 1;
    m_sw = 0; m_pact = 0; m_low_left = 0; m_high_left = 1; m_lfsr = SEED;
  endtask

  task automatic model_step();
    bit hs, in_rand;
    logic [15:0] lf;
    int r, lowt;
    hs = chan_if.valid && m_ready;
    lf = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    r = int'(lf[3:0] & MASK);
    if (cfg_load) begin
      m_pol  = int'(cfg_policy);
      m_low  = int'(cfg_low_cycles);
      m_high = (cfg_high_beats == 0) ? 1 : int'(cfg_high_beats);
      m_sw   = int'(cfg_switch_beats);
      m_beats = 0; m_stall = 0;
      case (m_pol)
        0: lowt = 0;
        1: lowt = m_low;
        2: lowt = r;
        default: lowt = (m_sw == 0) ? r : 0;
      endcase
      m_pact = (m_pol == 3) ? ((m_sw == 0) ? 2 : 0) : m_pol;
      if (lowt > 0) begin m_ready = 0; m_low_left = lowt; end
      else begin m_ready = 1; m_high_left = m_high; end
    end else begin
      if (chan_if.valid && !m_ready && m_stall < MAXC) m_stall++;
      if (hs && m_beats < MAXC) m_beats++;
      in_rand = (m_pol == 2) || (m_pol == 3 && m_beats >= m_sw);
      m_pact  = (m_pol == 3) ? (in_rand ? 2 : 0) : m_pol;
      if (!m_ready) begin
        if (m_pol == 0 || (m_pol == 3 && !in_rand)) begin
          m_ready = 1; m_high_left = m_high;
        end else if (chan_if.valid) begin
          m_low_left--;
          if (m_low_left == 0) begin m_ready = 1; m_high_left = m_high; end
        end
      end else if (hs) begin
        if (m_pol == 1) begin
          m_high_left--;
          if (m_high_left == 0) begin
            if (m_low > 0) begin m_ready = 0; m_low_left = m_low; end
            else m_high_left = m_high;
          end
        end else if (in_rand && r > 0) begin
          m_ready = 0; m_low_left = r;
        end
      end
    end
  endtask

  // One clock: DUT and model both consume the inputs set before the edge.
  task automatic tick();
    @(posedge aclk);
    model_step();
    cyc++;
    #1;
    check_val("ready", 32'(chan_if.ready), 32'(m_ready));
    check_val("beat_cnt", 32'(beat_cnt), 32'(m_beats));
    check_val("policy_active", 32'(policy_active), 32'(m_pact));
`ifdef AXI_READY_STATS_EN
    check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`else
    check_val("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    cfg_load = 1'b0;
  endtask

  task automatic load_cfg(input int pol, input int low, input int high, input int sw, input bit v);
    cfg_policy       = 2'(pol);
    cfg_low_cycles   = 8'(low);
    cfg_high_beats   = 8'(high);
    cfg_switch_beats = CNT_W'(sw);
    cfg_load         = 1'b1;
    chan_if.valid    = v;
    $display("cycle %0d: cfg_load policy=%0d low=%0d high=%0d switch=%0d", cyc, pol, low, high, sw);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(chan_if.ready), 32'd0);
    check_val({tag, "_beat"}, 32'(beat_cnt), 32'd0);
    check_val({tag, "_pact"}, 32'(policy_active), 32'd0);
    check_val({tag, "_stall"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    chan_if.valid = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    aresetn = 1'b1;

    // NOBP out of reset: ready from the second edge, 9 beats in 10 cycles.
    chan_if.valid = 1'b1;
    repeat (10) tick();
    check_val("nobp_beats", 32'(beat_cnt), 32'd9);

    // FIXED 3/2 loaded during a handshake: that beat is dropped.
    load_cfg(1, 3, 2, 0, 1'b1);
    check_val("load_clears_beats", 32'(beat_cnt), 32'd0);
    check_val("fixed_first_low", 32'(chan_if.ready), 32'd0);
    repeat (10) tick();
    check_val("fixed_two_periods", 32'(beat_cnt), 32'd4);

    // FIXED low=3 only counts cycles where valid is asserted.
    load_cfg(1, 3, 2, 0, 1'b0);
    chan_if.valid = 1'b1; tick();
    chan_if.valid = 1'b0; tick();
    chan_if.valid = 1'b1; tick();
    chan_if.valid = 1'b0; tick();
    check_val("toggle_still_low", 32'(chan_if.ready), 32'd0);
    chan_if.valid = 1'b1; tick();
    check_val("toggle_rises", 32'(chan_if.ready), 32'd1);

    // SWITCH after 4 beats, then LFSR-driven gaps.
    load_cfg(3, 0, 0, 4, 1'b1);
    repeat (4) tick();
    check_val("switch_beats", 32'(beat_cnt), 32'd4);
    check_val("switch_pact", 32'(policy_active), 32'd2);
    repeat (40) tick();

    // FIXED low=5 high=1: 10 stalled cycles and 2 beats in 12 cycles.
    load_cfg(1, 5, 1, 0, 1'b1);
    repeat (12) tick();
    check_val("stats_beats", 32'(beat_cnt), 32'd2);
`ifdef AXI_READY_STATS_EN
    check_val("stats_stall", 32'(stall_cnt), 32'd10);
`else
    check_val("stats_stall_off", 32'(stall_cnt), 32'd0);
`endif

    // Saturation of the beat counter.
    load_cfg(0, 0, 0, 0, 1'b1);
    repeat (MAXC + 20) tick();
    check_val("beat_saturates", 32'(beat_cnt), 32'(MAXC));

    // Saturation of the stall counter under a very long low time.
    load_cfg(1, 255, 1, 0, 1'b1);
    repeat (2 * MAXC + 30) tick();
`ifdef AXI_READY_STATS_EN
    check_val("stall_saturates", 32'(stall_cnt), 32'(MAXC));
`else
    check_val("stall_saturates_off", 32'(stall_cnt), 32'd0);
`endif

    // Randomized traffic with occasional reconfiguration and one async reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
      end
      chan_if.valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0)
        load_cfg($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3),
                 $urandom_range(0, 8), chan_if.valid);
      else
        tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
